// File: rtl/ad9866_agc_pkg.sv
// Shared types and constants for the AD9866 RX AGC.
// Ports: none (package only).
package ad9866_agc_pkg;

    typedef enum logic [1:0] {
        OFF,
        REQ,
        SETTLE,
        MEAS
    } agc_state_t;

    localparam logic [5:0] CMD_ADDR_RXGAIN = 6'h0a;
    localparam logic       RXGAIN_DIRECT   = 1'b1;

endpackage

// File: rtl/ad9866_agc_meter.sv
// Level meter: window counter plus saturating clip/good-level counters.
// Ports: clk, rst, clr, en, clip, good -> win_end, clip_hit_limit, quiet.
module ad9866_agc_meter #(
    parameter int WIN_LOG2   = 12,
    parameter int CLIP_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic clip,
    input  logic good,
    output logic win_end,
    output logic clip_hit_limit,
    output logic quiet
);

    localparam int CW = $clog2(CLIP_LIMIT + 1);

    logic [WIN_LOG2-1:0] win_cnt;
    logic [CW-1:0]       clip_cnt;
    logic [CW-1:0]       good_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            win_cnt  <= '0;
            clip_cnt <= '0;
            good_cnt <= '0;
        end else if (en) begin
            win_cnt <= win_cnt + 1'b1;
            if (clip && !(&clip_cnt))
                clip_cnt <= clip_cnt + 1'b1;
            if (good && !(&good_cnt))
                good_cnt <= good_cnt + 1'b1;
        end
    end

    assign win_end        = en && (&win_cnt);
    assign clip_hit_limit = en && clip &&
                            (clip_cnt == CW'(CLIP_LIMIT - 1));
    // The closing cycle's own flags belong to the window too.
    assign quiet = (clip_cnt == '0) && (good_cnt == '0) &&
                   !clip && !good;

endmodule

// File: rtl/ad9866_rxagc.sv
// AD9866 RX AGC: attack/decay gain control issuing 0x0a gain writes.
// Ports: clk, rst, agc_en, preset_gain, level flags, cmd_* handshake, agc_gain, agc_timeout.
module ad9866_rxagc
    import ad9866_agc_pkg::*;
#(
    parameter int WIN_LOG2      = 12,
    parameter int CLIP_LIMIT    = 4,
    parameter int ATTACK_STEP   = 6,
    parameter int HANG_WINDOWS  = 8,
    parameter int GAIN_MAX      = 60,
    parameter int SETTLE_CYCLES = 256,
    parameter int ACK_TIMEOUT   = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        agc_en,
    input  logic [5:0]  preset_gain,
    input  logic        rxclipp,
    input  logic        rxclipn,
    input  logic        rxgoodlvlp,
    input  logic        rxgoodlvln,
    output logic [5:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_rqst,
    input  logic        cmd_ack,
    output logic [5:0]  agc_gain,
    output logic        agc_timeout
);

    localparam logic [5:0] GMAX = 6'(GAIN_MAX);
    localparam logic [5:0] STEP = 6'(ATTACK_STEP);
    localparam int HW = $clog2(HANG_WINDOWS + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    agc_state_t    state;
    logic [5:0]    gain;
    logic [HW-1:0] hang_cnt;
    logic [TW-1:0] to_cnt;
    logic [SW-1:0] set_cnt;

    logic       in_meas;
    logic       meter_clr;
    logic       win_end;
    logic       clip_hit_limit;
    logic       quiet;
    logic [5:0] attack_gain;
    logic [5:0] preset_clamped;

    assign in_meas   = (state == MEAS);
    // Every window (and every attack) starts from cleared counts.
    assign meter_clr = !in_meas || clip_hit_limit || win_end;

    assign attack_gain    = (gain > STEP) ? gain - STEP : 6'd0;
    assign preset_clamped = (preset_gain > GMAX) ? GMAX : preset_gain;

    ad9866_agc_meter #(
        .WIN_LOG2   (WIN_LOG2),
        .CLIP_LIMIT (CLIP_LIMIT)
    ) u_meter (
        .clk            (clk),
        .rst            (rst),
        .clr            (meter_clr),
        .en             (in_meas),
        .clip           (rxclipp | rxclipn),
        .good           (rxgoodlvlp | rxgoodlvln),
        .win_end        (win_end),
        .clip_hit_limit (clip_hit_limit),
        .quiet          (quiet)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OFF;
            gain        <= '0;
            hang_cnt    <= '0;
            to_cnt      <= '0;
            set_cnt     <= '0;
            cmd_rqst    <= 1'b0;
            agc_timeout <= 1'b0;
        end else begin
            agc_timeout <= 1'b0;
            if (!agc_en) begin
                // Disable wins over a same-cycle ack.
                state    <= OFF;
                cmd_rqst <= 1'b0;
                hang_cnt <= '0;
                to_cnt   <= '0;
                set_cnt  <= '0;
            end else begin
                unique case (state)
                    OFF: begin
                        gain     <= preset_clamped;
                        to_cnt   <= '0;
                        cmd_rqst <= 1'b1;
                        state    <= REQ;
                    end
                    REQ: begin
                        if (cmd_ack) begin
                            cmd_rqst <= 1'b0;
                            set_cnt  <= '0;
                            state    <= SETTLE;
                        end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                            agc_timeout <= 1'b1;
                            cmd_rqst    <= 1'b0;
                            set_cnt     <= '0;
                            state       <= SETTLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (set_cnt == SW'(SETTLE_CYCLES - 1))
                            state <= MEAS;
                        else
                            set_cnt <= set_cnt + 1'b1;
                    end
                    MEAS: begin
                        if (clip_hit_limit) begin
                            hang_cnt <= '0;
                            if (attack_gain != gain) begin
                                gain     <= attack_gain;
                                to_cnt   <= '0;
                                cmd_rqst <= 1'b1;
                                state    <= REQ;
                            end
                        end else if (win_end) begin
                            if (!quiet) begin
                                hang_cnt <= '0;
                            end else if (hang_cnt == HW'(HANG_WINDOWS - 1)) begin
                                hang_cnt <= '0;
                                if (gain < GMAX) begin
                                    gain     <= gain + 1'b1;
                                    to_cnt   <= '0;
                                    cmd_rqst <= 1'b1;
                                    state    <= REQ;
                                end
                            end else begin
                                hang_cnt <= hang_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

    assign cmd_addr = CMD_ADDR_RXGAIN;
    assign cmd_data = {25'h0, RXGAIN_DIRECT, gain};
    assign agc_gain = gain;

endmodule

// File: tb/tb_ad9866_rxagc.sv
// Self-checking bench for ad9866_rxagc: directed plan plus random flags.
// Ports: none (top-level bench).
module tb_ad9866_rxagc;

    localparam int WL  = 6;
    localparam int WIN = 1 << WL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        agc_en = 1'b0;
    logic [5:0]  preset_gain = '0;
    logic        rxclipp = 1'b0;
    logic        rxclipn = 1'b0;
    logic        rxgoodlvlp = 1'b0;
    logic        rxgoodlvln = 1'b0;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        cmd_ack = 1'b0;
    logic [5:0]  agc_gain;
    logic        agc_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ad9866_rxagc #(.WIN_LOG2(WL)) dut (
        .clk         (clk),
        .rst         (rst),
        .agc_en      (agc_en),
        .preset_gain (preset_gain),
        .rxclipp     (rxclipp),
        .rxclipn     (rxclipn),
        .rxgoodlvlp  (rxgoodlvlp),
        .rxgoodlvln  (rxgoodlvln),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_rqst    (cmd_rqst),
        .cmd_ack     (cmd_ack),
        .agc_gain    (agc_gain),
        .agc_timeout (agc_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ad9866-like acceptor: acks once a request has been up ack_dly cycles.
    logic ack_on = 1'b1;
    int   ack_dly = 0;
    int   age = 0;
    always @(negedge clk) begin
        age     = cmd_rqst ? age + 1 : 0;
        cmd_ack = ack_on && cmd_rqst && (age > ack_dly);
    end

    // Reference model: phase + cycle counts derived from the rules.
    // phase 0 off, 1 requesting, 2 settling, 3 measuring.
    int m_phase = 0, m_gain = 0, m_req_cycles = 0, m_settle = 0;
    int m_pos = 0, m_clips = 0, m_hits = 0, m_quiet_run = 0;
    bit m_tmo = 0;

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic m_new_window();
        m_pos = 0;
        m_clips = 0;
        m_hits = 0;
    endtask

    task automatic m_request(input int g);
        m_gain = g;
        m_phase = 1;
        m_req_cycles = 0;
    endtask

    always @(posedge clk) begin
        bit c, g;
        int ng;
        c = rxclipp | rxclipn;
        g = rxgoodlvlp | rxgoodlvln;
        m_tmo = 0;
        if (rst) begin
            m_phase = 0; m_gain = 0; m_quiet_run = 0;
        end else if (!agc_en) begin
            m_phase = 0; m_quiet_run = 0;
        end else if (m_phase == 0) begin
            m_request((int'(preset_gain) > 60) ? 60 : int'(preset_gain));
        end else if (m_phase == 1) begin
            m_req_cycles++;
            if (cmd_ack) begin
                m_phase = 2; m_settle = 0;
            end else if (m_req_cycles == 63) begin
                m_tmo = 1; m_phase = 2; m_settle = 0;
            end
        end else if (m_phase == 2) begin
            m_settle++;
            if (m_settle == 256) begin
                m_phase = 3;
                m_new_window();
            end
        end else begin
            m_pos++;
            m_clips += int'(c);
            m_hits += int'(g);
            if (c && m_clips == 4) begin
                ng = mx(m_gain - 6, 0);
                m_quiet_run = 0;
                if (ng != m_gain) m_request(ng);
                else m_new_window();
            end else if (m_pos == WIN) begin
                if (m_clips == 0 && m_hits == 0) begin
                    m_quiet_run++;
                    if (m_quiet_run == 8) begin
                        m_quiet_run = 0;
                        if (m_gain < 60) m_request(m_gain + 1);
                    end
                end else begin
                    m_quiet_run = 0;
                end
                m_new_window();
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rqst", 32'(cmd_rqst), 32'(m_phase == 1));
            chk("data", cmd_data, {25'h0, 1'b1, 6'(m_gain)});
            chk("gain", 32'(agc_gain), 32'(m_gain));
            chk("tmo", 32'(agc_timeout), 32'(m_tmo));
            chk("addr", 32'(cmd_addr), 32'h0a);
        end
    end

    task automatic en_go(input logic [5:0] p);
        agc_en = 1'b0;
        cyc(2);
        preset_gain = p;
        agc_en = 1'b1;
        cyc(1);
    endtask

    task automatic clip_burst(input int n);
        rxclipp = 1'b1;
        cyc(n);
        rxclipp = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rqst"}, 32'(cmd_rqst), 32'h0);
        chk({tag, "_data"}, cmd_data, 32'h40);
        chk({tag, "_gain"}, 32'(agc_gain), 32'h0);
        chk({tag, "_addr"}, 32'(cmd_addr), 32'h0a);
        chk({tag, "_tmo"}, 32'(agc_timeout), 32'h0);
    endtask

    initial begin
        int n_rq, n_to, clip_rate, good_rate;
        cyc(3);
        check_reset_vals("reset");
        rst = 1'b0;
        chk_on = 1;
        cyc(2);

        // Enable with preset 40 and immediate ack.
        en_go(6'd40);
        chk("en_rqst", 32'(cmd_rqst), 32'h1);
        chk("en_data", cmd_data, 32'h68);
        cyc(1);
        chk("en_rqst_fall", 32'(cmd_rqst), 32'h0);
        cyc(259);

        // Attack: 4 clips at gain 40 -> 34.
        clip_burst(4);
        chk("atk_rqst", 32'(cmd_rqst), 32'h1);
        chk("atk_data", cmd_data, 32'h62);
        cyc(300);

        // Attack clamps at zero, then an attack at zero requests nothing.
        en_go(6'd3);
        cyc(259);
        clip_burst(4);
        chk("clamp_rqst", 32'(cmd_rqst), 32'h1);
        chk("clamp_gain", 32'(agc_gain), 32'h0);
        cyc(262);
        clip_burst(4);
        chk("zero_atk_rqst", 32'(cmd_rqst), 32'h0);
        n_rq = 0;
        for (int i = 0; i < WIN; i++) begin
            n_rq += int'(cmd_rqst);
            cyc(1);
        end
        chk("zero_atk_quiet", 32'(n_rq), 32'h0);

        // Decay: 59 -> 60 after 8 quiet windows, then held at max.
        en_go(6'd59);
        cyc(800);
        chk("decay_gain", 32'(agc_gain), 32'd60);
        n_rq = 0;
        for (int i = 0; i < 800; i++) begin
            n_rq += int'(cmd_rqst);
            cyc(1);
        end
        chk("decay_hold", 32'(n_rq), 32'h0);

        // Timeout with no ack.
        ack_on = 1'b0;
        en_go(6'd20);
        n_rq = 0;
        n_to = 0;
        for (int i = 0; i < 80; i++) begin
            n_rq += int'(cmd_rqst);
            n_to += int'(agc_timeout);
            cyc(1);
        end
        chk("to_rqst_cycles", 32'(n_rq), 32'd63);
        chk("to_pulses", 32'(n_to), 32'd1);
        cyc(300);

        // Disable mid-request.
        en_go(6'd10);
        cyc(5);
        agc_en = 1'b0;
        cyc(1);
        chk("dis_rqst", 32'(cmd_rqst), 32'h0);
        chk("dis_gain", 32'(agc_gain), 32'd10);
        ack_on = 1'b1;

        // Reset mid-measurement.
        en_go(6'd30);
        cyc(300);
        rst = 1'b1;
        cyc(1);
        check_reset_vals("rst_meas");
        rst = 1'b0;
        cyc(2);

        // Randomized flag traffic.
        for (int ph = 0; ph < 20; ph++) begin
            case ($urandom_range(0, 3))
                0: clip_rate = 0;
                1: clip_rate = 5;
                2: clip_rate = 30;
                default: clip_rate = 100;
            endcase
            case ($urandom_range(0, 2))
                0: good_rate = 0;
                1: good_rate = 5;
                default: good_rate = 50;
            endcase
            ack_dly = $urandom_range(0, 3);
            ack_on = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 1500; i++) begin
                bit c, g;
                c = ($urandom_range(0, 999) < clip_rate);
                g = ($urandom_range(0, 999) < good_rate);
                rxclipp = c & $urandom_range(0, 1);
                rxclipn = c & ~rxclipp;
                rxgoodlvlp = g & $urandom_range(0, 1);
                rxgoodlvln = g & ~rxgoodlvlp;
                if ($urandom_range(0, 2999) == 0) begin
                    agc_en = 1'b0;
                    preset_gain = 6'($urandom_range(0, 63));
                end else begin
                    agc_en = 1'b1;
                end
                cyc(1);
            end
        end
        rxclipp = 1'b0;
        rxclipn = 1'b0;
        rxgoodlvlp = 1'b0;
        rxgoodlvln = 1'b0;
        cyc(2);
        chk_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
